rabbit_g_sched: RTL and testbench
=================================

# rabbit_g_sched

Sequencer that computes one Rabbit next-state update by time-multiplexing a single shared g-function unit across the eight 32-bit state words. It issues each (counter, state) word pair to the external g unit, collects the eight g values, and combines them with the Rabbit rotate/add network into the eight new state words. It sits between the counter-update stage and the keystream extractor in the cipher core. The purpose is to replace eight parallel squarers with one.

## Interface
Parameters:
- G_LAT, default 0: pipeline latency of the attached g unit in cycles. Legal values are 0, 1 and 2. Value 0 means the unit is combinational.

Ports:
- clk  in  1  clock. All state changes on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  request one state update. Sampled only in IDLE.
- c_in  in  256  counter words. Word j is c_in[32j+31:32j].
- x_in  in  256  current state words, same packing as c_in.
- busy  out  1  high while an update is in progress.
- done  out  1  one-cycle pulse. Indicates x_out is updated.
- x_out  out  256  next-state words, same packing. Held until the next done.
- g_req  out  1  high in each cycle that a valid operand pair is issued to the g unit.
- g_cnt  out  32  counter operand to the g unit.
- g_st  out  32  state operand to the g unit.
- g_res  in  32  g unit result, defined as (u*u)[63:32] ^ (u*u)[31:0] where u = g_cnt + g_st mod 2^32. Valid G_LAT cycles after the matching g_req cycle.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, COMBINE.
- IDLE:
  - When start=1, latch c_in and x_in into internal registers, clear idx, and go to ISSUE.
  - When start=0, stay in IDLE.
- ISSUE (8 cycles, idx = 0..7):
  - Drive g_req=1, g_cnt = latched c[idx], g_st = latched x[idx].
  - After idx=7, go to DRAIN if G_LAT>0, otherwise go to COMBINE.
- DRAIN: G_LAT cycles with g_req=0, then go to COMBINE.
- Result capture: g_res is captured into g[k] on the edge G_LAT cycles after issue k. A delay line of g_req and idx tags each returning result; with G_LAT=0, g_res is captured on the same edge as the issue.
- COMBINE (1 cycle): register x_out and pulse done, then go to IDLE. All arithmetic is mod 2^32, and rotl is a 32-bit rotate left. Equations:
  - x0 = g0 + rotl(g7,16) + rotl(g6,16)
  - x1 = g1 + rotl(g0,8) + g7
  - x2 = g2 + rotl(g1,16) + rotl(g0,16)
  - x3 = g3 + rotl(g2,8) + g1
  - x4 = g4 + rotl(g3,16) + rotl(g2,16)
  - x5 = g5 + rotl(g4,8) + g3
  - x6 = g6 + rotl(g5,16) + rotl(g4,16)
  - x7 = g7 + rotl(g6,8) + g5
- g_cnt and g_st are 0 whenever g_req=0.
- Boundary conditions:
  - start while busy=1 is ignored, with no queueing.
  - start in the cycle where done=1 is accepted, because the FSM is already in IDLE.
  - c_in and x_in changes after the start edge have no effect on the current update.
  - rst_n low mid-update aborts it immediately. No done is produced and x_out returns to 0.

## Timing
- Reset values: busy=0, done=0, x_out=0, g_req=0, g_cnt=0, g_st=0, FSM=IDLE, idx=0, g registers=0.
- Let E0 be the edge where start is sampled in IDLE.
- Issue k (k = 0..7) is presented in the cycle after edge E(k); its result is captured at edge E(k+1+G_LAT).
- x_out is registered at edge E(9+G_LAT).
- done is high for exactly the one cycle after that edge.
- busy is high from after E0 until edge E(9+G_LAT), and is low in the done cycle.
- Throughput: one update every 10+G_LAT cycles with back-to-back start.

## Test plan
- Reset mid-update: assert rst_n low during ISSUE idx=3 -> all outputs are 0 immediately, no done follows, and the next start completes normally.
- All-zero inputs: all c and x words = 0, start -> every g = 0, x_out = 0, done after exactly 10+G_LAT cycles.
- Small operands: all c words = 1, all x words = 0, so every g = 1 -> x0 = x2 = x4 = x6 = 0x00020001 and x1 = x3 = x5 = x7 = 0x00000102.
- Wrap-around: all c words = 0xFFFFFFFF, all x words = 0, so every g = 0xFFFFFFFF -> every x word = 0xFFFFFFFD.
- Handshake:
  - Pulse start repeatedly while busy -> exactly one done per accepted start.
  - Assert start in the done cycle -> second update accepted with no idle gap.
- Latency sweep: run G_LAT = 0, 1, 2 with a g model delayed to match, using random c and x words -> x_out matches the software Rabbit next-state, and done timing equals 10+G_LAT.

Source files
------------

// File: rtl/rabbit_g_sched.sv
// rabbit_g_sched: computes one Rabbit next-state update with a single shared
// g-function unit. The unit is time-multiplexed across the eight state words.
// Each (counter, state) word pair is issued in turn. The returning g values are
// collected, and the rotate/add network combines them into x_out.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           request one update (sampled only while idle)
//   c_in, x_in      8 x 32-bit counter / state words, word j at [32j+31:32j]
//   busy            update in progress
//   done            one-cycle pulse when x_out has been refreshed
//   x_out           8 x 32-bit next-state words, held until the next done
//   g_req           operand pair valid toward the g unit this cycle
//   g_cnt, g_st     counter / state operand (zero when g_req is low)
//   g_res           g unit result, G_LAT cycles after its g_req cycle
module rabbit_g_sched #(
  parameter int unsigned G_LAT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] c_in,
  input  logic [255:0] x_in,
  output logic         busy,
  output logic         done,
  output logic [255:0] x_out,
  output logic         g_req,
  output logic [31:0]  g_cnt,
  output logic [31:0]  g_st,
  input  logic [31:0]  g_res
);

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned N_WORDS    = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned DRAIN_LAST = (G_LAT == 0) ? 0 : G_LAT - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_COMBINE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [255:0]       c_q, c_d;
  logic [255:0]       x_q, x_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [255:0]       xout_q, xout_d;
  logic               g_req_q, g_req_d;
  logic [WORD_W-1:0]  g_cnt_q, g_cnt_d;
  logic [WORD_W-1:0]  g_st_q, g_st_d;
  logic [WORD_W-1:0]  g_q [N_WORDS];
  logic [255:0]       x_new_c;
  logic               cap_vld_c;
  logic [IDX_W-1:0]   cap_idx_c;

  function automatic logic [WORD_W-1:0] word_at(input logic [255:0] v,
                                                input logic [IDX_W-1:0] i);
    word_at = v[{i, 5'd0} +: WORD_W];
  endfunction

  function automatic logic [WORD_W-1:0] rotl16(input logic [WORD_W-1:0] v);
    rotl16 = {v[15:0], v[31:16]};
  endfunction

  function automatic logic [WORD_W-1:0] rotl8(input logic [WORD_W-1:0] v);
    rotl8 = {v[23:0], v[31:24]};
  endfunction

  // Result tagging: g_res lines up with the issue made G_LAT cycles earlier.
  // The registered g_req/idx pair is that issue's tag.
  if (G_LAT == 0) begin : g_tap_comb
    assign cap_vld_c = g_req_q;
    assign cap_idx_c = idx_q;
  end else begin : g_tap_pipe
    logic             req_dl_q [G_LAT];
    logic [IDX_W-1:0] idx_dl_q [G_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(G_LAT); i++) begin
          req_dl_q[i] <= 1'b0;
          idx_dl_q[i] <= '0;
        end
      end else begin
        req_dl_q[0] <= g_req_q;
        idx_dl_q[0] <= idx_q;
        for (int i = 1; i < int'(G_LAT); i++) begin
          req_dl_q[i] <= req_dl_q[i-1];
          idx_dl_q[i] <= idx_dl_q[i-1];
        end
      end
    end

    assign cap_vld_c = req_dl_q[G_LAT-1];
    assign cap_idx_c = idx_dl_q[G_LAT-1];
  end

  // Rabbit rotate/add network over the collected g values.
  always_comb begin
    x_new_c[ 31:  0] = g_q[0] + rotl16(g_q[7]) + rotl16(g_q[6]);
    x_new_c[ 63: 32] = g_q[1] + rotl8(g_q[0])  + g_q[7];
    x_new_c[ 95: 64] = g_q[2] + rotl16(g_q[1]) + rotl16(g_q[0]);
    x_new_c[127: 96] = g_q[3] + rotl8(g_q[2])  + g_q[1];
    x_new_c[159:128] = g_q[4] + rotl16(g_q[3]) + rotl16(g_q[2]);
    x_new_c[191:160] = g_q[5] + rotl8(g_q[4])  + g_q[3];
    x_new_c[223:192] = g_q[6] + rotl16(g_q[5]) + rotl16(g_q[4]);
    x_new_c[255:224] = g_q[7] + rotl8(g_q[6])  + g_q[5];
  end

  // Next-state and registered-output logic. Issue operands are prepared one
  // cycle ahead, so g_req/g_cnt/g_st come straight from flops.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    c_d     = c_q;
    x_d     = x_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    xout_d  = xout_q;
    g_req_d = 1'b0;
    g_cnt_d = '0;
    g_st_d  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          c_d     = c_in;
          x_d     = x_in;
          idx_d   = '0;
          busy_d  = 1'b1;
          g_req_d = 1'b1;
          g_cnt_d = c_in[WORD_W-1:0];
          g_st_d  = x_in[WORD_W-1:0];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (idx_q == IDX_W'(N_WORDS - 1)) begin
          idx_d   = '0;
          state_d = (G_LAT == 0) ? S_COMBINE : S_DRAIN;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          g_req_d = 1'b1;
          g_cnt_d = word_at(c_q, idx_d);
          g_st_d  = word_at(x_q, idx_d);
        end
      end
      S_DRAIN: begin
        // idx is reused to count the drain cycles.
        if (idx_q == IDX_W'(DRAIN_LAST)) begin
          idx_d   = '0;
          state_d = S_COMBINE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_COMBINE: begin
        xout_d  = x_new_c;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      c_q     <= '0;
      x_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      xout_q  <= '0;
      g_req_q <= 1'b0;
      g_cnt_q <= '0;
      g_st_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      xout_q  <= xout_d;
      g_req_q <= g_req_d;
      g_cnt_q <= g_cnt_d;
      g_st_q  <= g_st_d;
    end
  end

  // g value capture from the tagged result stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_WORDS); i++) begin
        g_q[i] <= '0;
      end
    end else if (cap_vld_c) begin
      g_q[cap_idx_c] <= g_res;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign x_out = xout_q;
  assign g_req = g_req_q;
  assign g_cnt = g_cnt_q;
  assign g_st  = g_st_q;

endmodule

// File: tb/tb_rabbit_g_sched.sv
// Bench for rabbit_g_sched. It runs three instances (G_LAT = 0, 1, 2) in
// lockstep on shared stimulus. Each instance has its own latency-matched g
// model. Results are compared against a word-level Rabbit next-state model.
module tb_rabbit_g_sched;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [255:0] c_in;
  logic [255:0] x_in;

  logic         busy_w  [3];
  logic         done_w  [3];
  logic [255:0] xo_w    [3];
  logic         g_req_w [3];
  logic [31:0]  gc_w    [3];
  logic [31:0]  gs_w    [3];
  logic [31:0]  gr_w    [3];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [31:0] gfun(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] u;
    logic [63:0] sq;
    u  = a + b;
    sq = {32'd0, u} * {32'd0, u};
    return sq[63:32] ^ sq[31:0];
  endfunction

  function automatic logic [31:0] rl(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  // Even words mix two 16-bit rotations of the two preceding g values.
  // Odd words mix an 8-bit rotation of the previous g value and the one
  // before it, unrotated.
  function automatic logic [255:0] ref_next(input logic [255:0] c, input logic [255:0] x);
    logic [31:0]  g [8];
    logic [255:0] r;
    logic [31:0]  p1, p2;
    for (int j = 0; j < 8; j++) g[j] = gfun(c[32*j +: 32], x[32*j +: 32]);
    for (int j = 0; j < 8; j++) begin
      p1 = g[(j + 7) % 8];
      p2 = g[(j + 6) % 8];
      if (j % 2 == 0) r[32*j +: 32] = g[j] + rl(p1, 16) + rl(p2, 16);
      else            r[32*j +: 32] = g[j] + rl(p1, 8) + p2;
    end
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int j = 0; j < 8; j++) v[32*j +: 32] = $urandom();
    return v;
  endfunction

  for (genvar L = 0; L < 3; L++) begin : g_inst
    logic [31:0] gm0, gm1, gm2;

    rabbit_g_sched #(.G_LAT(L)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .c_in  (c_in),
      .x_in  (x_in),
      .busy  (busy_w[L]),
      .done  (done_w[L]),
      .x_out (xo_w[L]),
      .g_req (g_req_w[L]),
      .g_cnt (gc_w[L]),
      .g_st  (gs_w[L]),
      .g_res (gr_w[L])
    );

    assign gm0 = gfun(gc_w[L], gs_w[L]);
    always_ff @(posedge clk) begin
      gm1 <= gm0;
      gm2 <= gm1;
    end
    assign gr_w[L] = (L == 0) ? gm0 : ((L == 1) ? gm1 : gm2);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    for (int L = 0; L < 3; L++) begin
      chk($sformatf("%s_busy%0d", tag, L), 256'(busy_w[L]), '0);
      chk($sformatf("%s_done%0d", tag, L), 256'(done_w[L]), '0);
      chk($sformatf("%s_xout%0d", tag, L), xo_w[L], '0);
      chk($sformatf("%s_greq%0d", tag, L), 256'(g_req_w[L]), '0);
      chk($sformatf("%s_gcnt%0d", tag, L), 256'(gc_w[L]), '0);
      chk($sformatf("%s_gst%0d", tag, L), 256'(gs_w[L]), '0);
    end
  endtask

  // One update on all instances. Inputs are scrambled after the start edge.
  task automatic do_update(input logic [255:0] c, input logic [255:0] x, input string tag);
    logic [255:0] exp;
    int dcyc [3];
    int dn   [3];
    int rq   [3];
    exp = ref_next(c, x);
    for (int L = 0; L < 3; L++) begin
      dcyc[L] = -1;
      dn[L]   = 0;
      rq[L]   = 0;
    end
    start = 1'b1;
    c_in  = c;
    x_in  = x;
    tick();
    start = 1'b0;
    c_in  = rand256();
    x_in  = rand256();
    for (int cyc = 1; cyc <= 20; cyc++) begin
      for (int L = 0; L < 3; L++) if (g_req_w[L]) rq[L]++;
      tick();
      for (int L = 0; L < 3; L++) begin
        if (done_w[L]) begin
          dn[L]++;
          dcyc[L] = cyc;
        end
      end
    end
    for (int L = 0; L < 3; L++) begin
      chk($sformatf("%s_lat%0d", tag, L), 256'(dcyc[L]), 256'(9 + L));
      chk($sformatf("%s_ndone%0d", tag, L), 256'(dn[L]), 256'd1);
      chk($sformatf("%s_nreq%0d", tag, L), 256'(rq[L]), 256'd8);
      chk($sformatf("%s_xout%0d", tag, L), xo_w[L], exp);
    end
  endtask

  // Extra start pulses while busy must be dropped.
  task automatic pulse_busy();
    logic [255:0] c, x, exp;
    int dn [3];
    c   = rand256();
    x   = rand256();
    exp = ref_next(c, x);
    for (int L = 0; L < 3; L++) dn[L] = 0;
    start = 1'b1;
    c_in  = c;
    x_in  = x;
    tick();
    for (int cyc = 1; cyc <= 30; cyc++) begin
      start = (cyc == 2 || cyc == 4 || cyc == 6);
      c_in  = rand256();
      x_in  = rand256();
      tick();
      for (int L = 0; L < 3; L++) if (done_w[L]) dn[L]++;
    end
    start = 1'b0;
    for (int L = 0; L < 3; L++) begin
      chk($sformatf("pulse_ndone%0d", L), 256'(dn[L]), 256'd1);
      chk($sformatf("pulse_xout%0d", L), xo_w[L], exp);
    end
  endtask

  // Start asserted in instance L's done cycle is taken with no gap.
  task automatic b2b(input int L);
    logic [255:0] c1, x1, c2, x2;
    int cyc;
    c1 = rand256();
    x1 = rand256();
    c2 = rand256();
    x2 = rand256();
    start = 1'b1;
    c_in  = c1;
    x_in  = x1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!done_w[L] && cyc < 30) begin
      tick();
      cyc++;
    end
    chk($sformatf("b2b_lat_a%0d", L), 256'(cyc), 256'(9 + L));
    chk($sformatf("b2b_xout_a%0d", L), xo_w[L], ref_next(c1, x1));
    start = 1'b1;
    c_in  = c2;
    x_in  = x2;
    tick();
    start = 1'b0;
    chk($sformatf("b2b_busy%0d", L), 256'(busy_w[L]), 256'd1);
    cyc = 1;
    while (!done_w[L] && cyc < 30) begin
      tick();
      cyc++;
    end
    chk($sformatf("b2b_period%0d", L), 256'(cyc), 256'(10 + L));
    chk($sformatf("b2b_xout_b%0d", L), xo_w[L], ref_next(c2, x2));
    repeat (30) tick();
  endtask

  initial begin
    logic [255:0] c, x;
    int dn [3];

    rst_n = 1'b0;
    start = 1'b0;
    c_in  = '0;
    x_in  = '0;
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    do_update('0, '0, "zero");

    do_update({8{32'h1}}, '0, "small");
    chk("small_x0", 256'(xo_w[0][31:0]), 256'h00020001);
    chk("small_x1", 256'(xo_w[0][63:32]), 256'h00000102);
    chk("small_x6", 256'(xo_w[2][223:192]), 256'h00020001);
    chk("small_x7", 256'(xo_w[2][255:224]), 256'h00000102);

    do_update({8{32'hFFFFFFFF}}, '0, "wrap");
    for (int L = 0; L < 3; L++) chk($sformatf("wrap_const%0d", L), xo_w[L], {8{32'hFFFFFFFD}});

    for (int i = 0; i < 6; i++) do_update(rand256(), rand256(), $sformatf("rnd%0d", i));

    pulse_busy();
    for (int L = 0; L < 3; L++) b2b(L);

    // Abort mid-update while issue 3 is on the g port.
    c = rand256();
    x = rand256();
    start = 1'b1;
    c_in  = c;
    x_in  = x;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("abort_greq", 256'(g_req_w[0]), 256'd1);
    chk("abort_gcnt3", 256'(gc_w[0]), 256'(c[127:96]));
    chk("abort_gst3", 256'(gs_w[0]), 256'(x[127:96]));
    rst_n = 1'b0;
    #1;
    chk_zero("abort");
    repeat (2) tick();
    rst_n = 1'b1;
    for (int L = 0; L < 3; L++) dn[L] = 0;
    repeat (20) begin
      tick();
      for (int L = 0; L < 3; L++) if (done_w[L]) dn[L]++;
    end
    for (int L = 0; L < 3; L++) chk($sformatf("abort_nodone%0d", L), 256'(dn[L]), '0);

    do_update(rand256(), rand256(), "post_abort");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
